// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller takes the master view; the datapath (or a bench) takes the slave view.
interface multicycle_control_fsm_if #(
    parameter int unsigned CNT_W = 16
);
    logic             enable;
    logic [5:0]       opCode;
    logic             zero;

    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             MemtoReg;
    logic             IRWrite;
    logic             ALUSrcA;
    logic             RegWrite;
    logic             RegDst;
    logic [1:0]       PCSource;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;

    logic [3:0]       state_dbg;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_retired;

    modport master (
        input  enable, opCode, zero,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp,
               state_dbg, illegal_op, instr_retired
    );

    modport slave (
        output enable, opCode, zero,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp,
               state_dbg, illegal_op, instr_retired
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore control unit for the multicycle word-addressed datapath: one state per
// datapath cycle, with freeze, sticky illegal-opcode flag and retired-instruction count.
module multicycle_control_fsm #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_control_fsm_if.master bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        FETCH      = 4'd0,
        FETCH_WAIT = 4'd1,
        DECODE     = 4'd2,
        MEM_ADDR   = 4'd3,
        MEM_READ   = 4'd4,
        MEM_WB     = 4'd5,
        MEM_WRITE  = 4'd6,
        EXECUTE    = 4'd7,
        R_WB       = 4'd8,
        BRANCH     = 4'd9,
        JUMP       = 4'd10,
        ADDI_EXEC  = 4'd11,
        ADDI_WB    = 4'd12
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    state_e           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             is_sw_q, is_sw_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             go_c;
    logic             unused_zero;

    // Branch resolution uses zero inside the datapath's PC-enable logic, not here.
    assign unused_zero = bus.zero;

    // Per-state control word; memory-path states keep the MEM_ADDR ALU selects
    // so the free-running ALUOut register holds the effective address.
    function automatic ctrl_t decode(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            FETCH_WAIT: begin
                c.mem_read = 1'b1;
                c.ir_write = 1'b1;
            end
            DECODE: c.alu_src_b = 2'b10;
            MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEM_READ: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.iord      = 1'b1;
                c.mem_read  = 1'b1;
            end
            MEM_WB: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = 2'b10;
                c.iord       = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            MEM_WRITE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            R_WB: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_source     = 2'b01;
                c.pc_write_cond = 1'b1;
            end
            JUMP: begin
                c.pc_source = 2'b10;
                c.pc_write  = 1'b1;
            end
            ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ADDI_WB: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.reg_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next state, sticky flag and retire count; everything holds while frozen.
    always_comb begin
        state_d   = state_q;
        is_sw_d   = is_sw_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        if (bus.enable) begin
            case (state_q)
                FETCH:      state_d = FETCH_WAIT;
                FETCH_WAIT: state_d = DECODE;
                DECODE: begin
                    is_sw_d = (bus.opCode == OP_SW);
                    case (bus.opCode)
                        OP_LW, OP_SW: state_d = MEM_ADDR;
                        OP_RTYPE:     state_d = EXECUTE;
                        OP_BEQ:       state_d = BRANCH;
                        OP_J:         state_d = JUMP;
                        OP_ADDI:      state_d = ADDI_EXEC;
                        default: begin
                            state_d   = FETCH;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
                MEM_ADDR:  state_d = is_sw_q ? MEM_WRITE : MEM_READ;
                MEM_READ:  state_d = MEM_WB;
                EXECUTE:   state_d = R_WB;
                ADDI_EXEC: state_d = ADDI_WB;
                MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB: begin
                    state_d = FETCH;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
                default: state_d = FETCH;
            endcase
        end
    end

    assign ctrl_d = decode(state_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            ctrl_q    <= decode(FETCH);
            is_sw_q   <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            is_sw_q   <= is_sw_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    // Writes and reads are squashed immediately on freeze or reset; selects are not.
    assign go_c = bus.enable & ~reset;

    assign bus.PCWrite       = ctrl_q.pc_write      & go_c;
    assign bus.PCWriteCond   = ctrl_q.pc_write_cond & go_c;
    assign bus.MemRead       = ctrl_q.mem_read      & go_c;
    assign bus.MemWrite      = ctrl_q.mem_write     & go_c;
    assign bus.IRWrite       = ctrl_q.ir_write      & go_c;
    assign bus.RegWrite      = ctrl_q.reg_write     & go_c;
    assign bus.IorD          = ctrl_q.iord;
    assign bus.MemtoReg      = ctrl_q.mem_to_reg;
    assign bus.ALUSrcA       = ctrl_q.alu_src_a;
    assign bus.RegDst        = ctrl_q.reg_dst;
    assign bus.PCSource      = ctrl_q.pc_source;
    assign bus.ALUSrcB       = ctrl_q.alu_src_b;
    assign bus.ALUOp         = ctrl_q.alu_op;
    assign bus.state_dbg     = state_q;
    assign bus.illegal_op    = illegal_q;
    assign bus.instr_retired = cnt_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: instruction table, hand-built freeze/reset
// sequences, then random instruction streams with random freezes against a reference model.
module tb_multicycle_control_fsm;

    localparam int unsigned CNT_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_fsm_if #(.CNT_W(CNT_W)) bus ();
    multicycle_control_fsm #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;
    logic [CNT_W-1:0] model_cnt;
    logic             model_ill;
    int               seq_q[$];

    typedef struct {
        logic [5:0]       op;
        logic             zero;
        int               cycles;
        logic             ill;
        logic [CNT_W-1:0] cnt;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [19:0] obs();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.MemtoReg, bus.IRWrite, bus.ALUSrcA, bus.RegWrite, bus.RegDst,
                bus.PCSource, bus.ALUSrcB, bus.ALUOp, bus.state_dbg};
    endfunction

    // Expected control word for a datapath step, written from the step's listed strobes.
    function automatic logic [19:0] exp_obs(input int s, input bit en);
        logic pcw, pcwc, iord, memr, memw, mtr, irw, srca, regw, regdst;
        logic [1:0] pcsrc, srcb, aluop;
        {pcw, pcwc, iord, memr, memw, mtr, irw, srca, regw, regdst} = '0;
        pcsrc = 2'b00; srcb = 2'b00; aluop = 2'b00;
        case (s)
            0:  begin memr = 1'b1; srcb = 2'b01; pcw = 1'b1; end
            1:  begin memr = 1'b1; irw = 1'b1; end
            2:  srcb = 2'b10;
            3:  begin srca = 1'b1; srcb = 2'b10; end
            4:  begin srca = 1'b1; srcb = 2'b10; iord = 1'b1; memr = 1'b1; end
            5:  begin srca = 1'b1; srcb = 2'b10; iord = 1'b1; mtr = 1'b1; regw = 1'b1; end
            6:  begin srca = 1'b1; srcb = 2'b10; iord = 1'b1; memw = 1'b1; end
            7:  begin srca = 1'b1; aluop = 2'b10; end
            8:  begin srca = 1'b1; aluop = 2'b10; regdst = 1'b1; regw = 1'b1; end
            9:  begin srca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; pcwc = 1'b1; end
            10: begin pcsrc = 2'b10; pcw = 1'b1; end
            11: begin srca = 1'b1; srcb = 2'b10; end
            12: begin srca = 1'b1; srcb = 2'b10; regw = 1'b1; end
            default: ;
        endcase
        if (!en) {pcw, pcwc, memr, memw, irw, regw} = '0;
        return {pcw, pcwc, iord, memr, memw, mtr, irw, srca, regw, regdst,
                pcsrc, srcb, aluop, 4'(s)};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
               op == OP_BEQ || op == OP_J || op == OP_ADDI;
    endfunction

    // Every instruction is fetch (0,1) and decode (2), then its opcode-specific steps.
    task automatic build_seq(input logic [5:0] op);
        seq_q.delete();
        seq_q.push_back(0); seq_q.push_back(1); seq_q.push_back(2);
        case (op)
            OP_LW:    begin seq_q.push_back(3); seq_q.push_back(4); seq_q.push_back(5); end
            OP_SW:    begin seq_q.push_back(3); seq_q.push_back(6); end
            OP_RTYPE: begin seq_q.push_back(7); seq_q.push_back(8); end
            OP_BEQ:   seq_q.push_back(9);
            OP_J:     seq_q.push_back(10);
            OP_ADDI:  begin seq_q.push_back(11); seq_q.push_back(12); end
            default:  ;
        endcase
    endtask

    task automatic run_model(input logic [5:0] op, input int unsigned freeze_pct);
        int s;
        int nf;
        build_seq(op);
        foreach (seq_q[i]) begin
            s  = seq_q[i];
            nf = ($urandom_range(99) < freeze_pct) ? int'($urandom_range(1, 3)) : 0;
            for (int k = 0; k < nf; k++) begin
                bus.enable = 1'b0;
                bus.opCode = 6'($urandom);
                bus.zero   = 1'($urandom);
                @(negedge clk);
                chk("frozen_ctrl", 32'(obs()), 32'(exp_obs(s, 1'b0)));
                chk("frozen_cnt", 32'(bus.instr_retired), 32'(model_cnt));
                @(posedge clk); #1;
            end
            bus.enable = 1'b1;
            bus.opCode = (s == 2) ? op : 6'($urandom);
            bus.zero   = 1'($urandom);
            @(negedge clk);
            chk("ctrl", 32'(obs()), 32'(exp_obs(s, 1'b1)));
            chk("illegal", 32'(bus.illegal_op), 32'(model_ill));
            chk("retired", 32'(bus.instr_retired), 32'(model_cnt));
            @(posedge clk); #1;
        end
        if (is_legal(op)) model_cnt = model_cnt + CNT_W'(1);
        else              model_ill = 1'b1;
    endtask

    initial begin
        logic [5:0] legal_ops[6];
        logic [5:0] op;
        int         ncyc;

        legal_ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
        tbl[0] = '{OP_LW,    1'b0, 6, 1'b0, 4'd1};
        tbl[1] = '{OP_SW,    1'b0, 5, 1'b0, 4'd2};
        tbl[2] = '{OP_RTYPE, 1'b1, 5, 1'b0, 4'd3};
        tbl[3] = '{OP_BEQ,   1'b1, 4, 1'b0, 4'd4};
        tbl[4] = '{OP_BEQ,   1'b0, 4, 1'b0, 4'd5};
        tbl[5] = '{OP_J,     1'b0, 4, 1'b0, 4'd6};
        tbl[6] = '{6'b111111, 1'b0, 3, 1'b1, 4'd6};
        tbl[7] = '{OP_ADDI,  1'b0, 5, 1'b1, 4'd7};

        // Power-on reset with enable high: strobes gated, FETCH selects visible.
        reset = 1'b1; bus.enable = 1'b1; bus.opCode = '0; bus.zero = 1'b0;
        #2;
        chk("reset_ctrl", 32'(obs()), 32'(exp_obs(0, 1'b0)));
        chk("reset_cnt", 32'(bus.instr_retired), 32'd0);
        chk("reset_ill", 32'(bus.illegal_op), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Instruction table: cycles FETCH-to-FETCH, flag and count after each.
        for (int i = 0; i < 8; i++) begin
            bus.opCode = tbl[i].op;
            bus.zero   = tbl[i].zero;
            bus.enable = 1'b1;
            ncyc = 0;
            do begin
                @(posedge clk); #1;
                ncyc++;
            end while (bus.state_dbg != 4'd0 && ncyc < 12);
            chk("tbl_cycles", 32'(ncyc), 32'(tbl[i].cycles));
            chk("tbl_illegal", 32'(bus.illegal_op), 32'(tbl[i].ill));
            chk("tbl_retired", 32'(bus.instr_retired), 32'(tbl[i].cnt));
        end
        model_cnt = 4'd7;
        model_ill = 1'b1;

        // Freeze three cycles in FETCH_WAIT, then IRWrite must pulse once.
        bus.opCode = OP_ADDI;
        @(posedge clk); #1;
        bus.enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("frz_state", 32'(bus.state_dbg), 32'd1);
            chk("frz_irwrite", 32'(bus.IRWrite), 32'd0);
            @(posedge clk); #1;
        end
        bus.enable = 1'b1;
        @(negedge clk);
        chk("resume_irwrite", 32'(bus.IRWrite), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("resume_state", 32'(bus.state_dbg), 32'd2);
        chk("resume_irwrite_off", 32'(bus.IRWrite), 32'd0);
        for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
        model_cnt = model_cnt + CNT_W'(1);
        chk("resume_done_state", 32'(bus.state_dbg), 32'd0);
        chk("resume_done_cnt", 32'(bus.instr_retired), 32'(model_cnt));

        // Async reset in MEM_WRITE abandons the store immediately.
        bus.opCode = OP_SW;
        for (int k = 0; k < 4; k++) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("sw_memwrite", 32'(bus.MemWrite), 32'd1);
        chk("sw_state", 32'(bus.state_dbg), 32'd6);
        #2 reset = 1'b1;
        #1;
        chk("arst_memwrite", 32'(bus.MemWrite), 32'd0);
        chk("arst_state", 32'(bus.state_dbg), 32'd0);
        chk("arst_cnt", 32'(bus.instr_retired), 32'd0);
        chk("arst_ill", 32'(bus.illegal_op), 32'd0);
        @(posedge clk); #1;
        chk("arst_hold_state", 32'(bus.state_dbg), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_pcwrite", 32'(bus.PCWrite), 32'd1);
        chk("post_rst_srcb", 32'(bus.ALUSrcB), 32'd1);
        @(posedge clk); #1;
        chk("post_rst_state", 32'(bus.state_dbg), 32'd1);
        bus.opCode = OP_J;
        for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
        chk("post_rst_cnt", 32'(bus.instr_retired), 32'd1);

        // Sixteen jumps from a cleared counter wrap it back to zero.
        reset = 1'b1; #2 reset = 1'b0;
        model_cnt = '0; model_ill = 1'b0;
        for (int k = 0; k < 16; k++) run_model(OP_J, 0);
        chk("wrap_cnt", 32'(bus.instr_retired), 32'd0);
        run_model(OP_BEQ, 0);
        run_model(OP_LW, 0);

        // Random instruction stream with random freezes.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(9) == 0) op = 6'($urandom);
            else                        op = legal_ops[$urandom_range(5)];
            run_model(op, 25);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
